// File: rtl/qsn_right_pipe.sv
// Pipelined right cyclic shifter for the QC-LDPC network: rotates Z lanes of W bits right
// by in_sel mod Z, one register stage per shift bit, valid/ready with global stall.
module qsn_right_pipe #(
    parameter int unsigned Z  = 3,
    parameter int unsigned W  = 4,
    parameter int unsigned SW = 2
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic [Z*W-1:0]    in_data,
    input  logic [SW-1:0]     in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [Z*W-1:0]    out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned DW = Z * W;

    // Lane i of the result takes lane (i - r) mod Z of the source.
    function automatic logic [DW-1:0] rot_right(input logic [DW-1:0] v, input int unsigned r);
        logic [DW-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < Z; i++) begin
            res[i*W +: W] = v[((i + Z - r) % Z)*W +: W];
        end
        return res;
    endfunction

    logic [SW-1:0]          sel_norm_c;
    logic                   stall_c;

    logic [SW-1:0][DW-1:0]  data_q, data_d;
    logic [SW-1:0][SW-1:0]  sel_q,  sel_d;
    logic [SW-1:0]          vld_q,  vld_d;

    // in_sel never exceeds 2Z-1, so a single conditional subtract yields in_sel mod Z.
    assign sel_norm_c = (in_sel >= SW'(Z)) ? (in_sel - SW'(Z)) : in_sel;

    assign stall_c   = out_valid & ~out_ready;
    assign in_ready  = ~stall_c;
    assign out_data  = data_q[SW-1];
    assign out_valid = vld_q[SW-1];

    for (genvar k = 0; k < SW; k++) begin : g_stage
        localparam int unsigned ROT = (1 << k) % Z;

        logic [DW-1:0] src_data_c;
        logic [SW-1:0] src_sel_c;
        logic          src_vld_c;

        if (k == 0) begin : g_first
            assign src_data_c = in_data;
            assign src_sel_c  = sel_norm_c;
            assign src_vld_c  = in_valid;
        end else begin : g_rest
            assign src_data_c = data_q[k-1];
            assign src_sel_c  = sel_q[k-1];
            assign src_vld_c  = vld_q[k-1];
        end

        assign data_d[k] = src_sel_c[k] ? rot_right(src_data_c, ROT) : src_data_c;
        assign sel_d[k]  = src_sel_c;
        assign vld_d[k]  = src_vld_c;
    end

    // All stages advance together; a stall freezes the whole pipe.
    always_ff @(posedge sys_clk or posedge rstn) begin
        if (rstn) begin
            data_q <= '0;
            sel_q  <= '0;
            vld_q  <= '0;
        end else if (!stall_c) begin
            data_q <= data_d;
            sel_q  <= sel_d;
            vld_q  <= vld_d;
        end
    end

endmodule

// File: tb/tb_qsn_right_pipe.sv
// Directed bench for qsn_right_pipe: hand-computed rotations plus a scoreboard of
// expected beats for streaming, back-pressure, reset and inverse-rotation sequences.
module tb_qsn_right_pipe;

    localparam int Z  = 3;
    localparam int W  = 4;
    localparam int SW = 2;
    localparam int DW = Z * W;

    logic              sys_clk = 1'b0;
    logic              rstn;
    logic [DW-1:0]     in_data;
    logic [SW-1:0]     in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;

    int                checks = 0;
    int                errors = 0;
    int                n_out  = 0;
    logic [DW-1:0]     exp_q[$];

    always #5 sys_clk = ~sys_clk;

    qsn_right_pipe #(.Z(Z), .W(W), .SW(SW)) dut (
        .sys_clk  (sys_clk),
        .rstn     (rstn),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Golden rotation by s mod Z; left=1 gives the read-path rotation.
    function automatic logic [DW-1:0] rot(input logic [DW-1:0] v, input int s, input bit left);
        logic [DW-1:0] r;
        int sm;
        sm = s % Z;
        r  = '0;
        for (int i = 0; i < Z; i++) begin
            int src;
            src = left ? (i + sm) % Z : (i + Z - sm) % Z;
            r[i*W +: W] = v[src*W +: W];
        end
        return r;
    endfunction

    // One clock: drive, score any emitted beat, queue the expectation of any accepted beat.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] s,
                        input logic ordy, input logic [DW-1:0] e, input string tag,
                        output logic acc);
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) chk({tag, "_spurious"}, 32'd1, 32'd0);
            else                   chk(tag, 32'(out_data), 32'(exp_q.pop_front()));
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(e);
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        logic          acc;
        logic [DW-1:0] d, od;
        logic [SW-1:0] s;
        logic [DW-1:0] tv[6];
        logic [SW-1:0] ts[6];
        int            n0, first, idx;

        rstn = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge sys_clk); #1;
        rstn = 1'b0;
        @(posedge sys_clk); #1;

        // Directed rotations of {C,B,A}, with latency checked on the first beat
        step(1'b1, 12'hCBA, 2'd1, 1'b1, 12'hBAC, "sel1", acc);
        chk("lat_edge1", 32'(out_valid), 32'd0);
        step(1'b0, 12'h000, 2'd0, 1'b1, 12'h000, "sel1", acc);
        chk("lat_edge2", 32'(out_valid), 32'd1);
        step(1'b1, 12'hCBA, 2'd2, 1'b1, 12'hACB, "sel2", acc);
        step(1'b1, 12'hCBA, 2'd0, 1'b1, 12'hCBA, "sel0", acc);
        step(1'b1, 12'hCBA, 2'd3, 1'b1, 12'hCBA, "sel3", acc);
        step(1'b1, 12'h123, 2'd1, 1'b1, 12'h231, "sel1_123", acc);
        step(1'b1, 12'h5A3, 2'd2, 1'b1, 12'h35A, "sel2_5A3", acc);
        for (int i = 0; i < 3; i++) step(1'b0, 12'h000, 2'd0, 1'b1, 12'h000, "drain0", acc);
        chk("directed_count", 32'(n_out), 32'd6);

        // Streaming: 8 back-to-back beats
        n0 = n_out; first = -1;
        for (int i = 0; i < 11; i++) begin
            if (out_valid && first < 0) first = i;
            d = DW'($urandom);
            s = SW'($urandom_range(0, 3));
            if (i < 8) begin
                out_ready = 1'b1; #1;
                chk("stream_in_ready", 32'(in_ready), 32'd1);
            end
            step(i < 8, d, s, 1'b1, rot(d, int'(s), 1'b0), "stream", acc);
        end
        chk("stream_first_valid", 32'(first), 32'd2);
        chk("stream_count", 32'(n_out - n0), 32'd8);

        // Back-pressure: fill, stall 5 cycles, then drain
        n0 = n_out;
        step(1'b1, 12'h9E1, 2'd1, 1'b1, rot(12'h9E1, 1, 1'b0), "bp", acc);
        step(1'b1, 12'h4C7, 2'd2, 1'b1, rot(12'h4C7, 2, 1'b0), "bp", acc);
        od = out_data;
        chk("bp_full_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0; #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_stable", 32'(out_data), 32'(od));
            step(1'b1, 12'hFFF, 2'd3, 1'b0, 12'hFFF, "bp_stall", acc);
        end
        step(1'b1, 12'h6D2, 2'd3, 1'b1, 12'h6D2, "bp", acc);
        for (int i = 0; i < 3; i++) step(1'b0, 12'h000, 2'd0, 1'b1, 12'h000, "bp", acc);
        chk("bp_count", 32'(n_out - n0), 32'd3);

        // out_ready toggling every cycle
        n0 = n_out; idx = 0;
        for (int i = 0; i < 6; i++) begin
            tv[i] = DW'($urandom);
            ts[i] = SW'($urandom_range(0, 3));
        end
        for (int c = 0; c < 30; c++) begin
            if (idx < 6) begin
                step(1'b1, tv[idx], ts[idx], c[0], rot(tv[idx], int'(ts[idx]), 1'b0), "toggle", acc);
                if (acc) idx++;
            end else begin
                step(1'b0, 12'h000, 2'd0, c[0], 12'h000, "toggle", acc);
            end
        end
        chk("toggle_count", 32'(n_out - n0), 32'd6);
        chk("toggle_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with two beats in flight
        step(1'b1, 12'h111, 2'd1, 1'b0, 12'h111, "rst_old", acc);
        step(1'b1, 12'h222, 2'd2, 1'b0, 12'h222, "rst_old", acc);
        chk("rst_mid_pre_valid", 32'(out_valid), 32'd1);
        rstn = 1'b1;
        #1;
        chk("rst_mid_valid_async", 32'(out_valid), 32'd0);
        chk("rst_mid_data_async", 32'(out_data), 32'd0);
        exp_q.delete();
        @(posedge sys_clk); #1;
        rstn = 1'b0;
        n0 = n_out;
        step(1'b1, 12'h5A3, 2'd2, 1'b1, 12'h35A, "rst_new", acc);
        chk("rst_new_edge1", 32'(out_valid), 32'd0);
        step(1'b0, 12'h000, 2'd0, 1'b1, 12'h000, "rst_new", acc);
        chk("rst_new_edge2", 32'(out_valid), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 12'h000, 2'd0, 1'b1, 12'h000, "rst_new", acc);
        chk("rst_new_count", 32'(n_out - n0), 32'd1);

        // Inverse property: left-rotated vector comes back unchanged
        n0 = n_out;
        for (int sv = 0; sv < 4; sv++) begin
            for (int j = 0; j < 3; j++) begin
                d = DW'($urandom);
                step(1'b1, rot(d, sv, 1'b1), SW'(sv), 1'b1, d, "inverse", acc);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0, 12'h000, 2'd0, 1'b1, 12'h000, "inverse", acc);
        chk("inverse_count", 32'(n_out - n0), 32'd12);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
